// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch predictor: funct3 encodings and the
// 2-bit saturating direction counter.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic [1:0] {
    CtrStrongNt = 2'b00,
    CtrWeakNt   = 2'b01,
    CtrWeakT    = 2'b10,
    CtrStrongT  = 2'b11
  } ctr_t;

  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    ctr_t n;
    n = c;
    if (taken && (c != CtrStrongT)) begin
      n = ctr_t'(c + 2'd1);
    end else if (!taken && (c != CtrStrongNt)) begin
      n = ctr_t'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_cond_decode.sv
// Maps funct3 and the comparator flags to a branch condition; also selects
// signed/unsigned comparison for the comparator.
module branch_cond_decode
  import branch_pkg::*;
(
  input  logic [2:0] fun3_i,
  input  logic       beq_i,
  input  logic       blt_i,
  output logic       cond_o,
  output logic       br_un_o
);

  assign br_un_o = fun3_i[1];

  always_comb begin
    cond_o = 1'b0;
    case (fun3_i)
      BEQ:         cond_o = beq_i;
      BNE:         cond_o = ~beq_i;
      BLT, BLTU:   cond_o = blt_i;
      BGE, BGEU:   cond_o = ~blt_i;
      default:     cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup for IF,
// branch resolution, redirect and table training for EX.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_if,
  output logic            pred_taken_if,
  output logic [XLEN-1:0] pred_target_if,
  input  logic            ex_valid,
  input  logic            Branch,
  input  logic            Jump,
  input  logic            beq,
  input  logic            blt,
  input  logic [2:0]      fun3,
  output logic            BrUn,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] target_ex,
  input  logic            pred_taken_ex,
  input  logic [XLEN-1:0] pred_target_ex,
  output logic            PcSrc,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  ctr_t               ctr_q [ENTRIES];
  ctr_t               ctr_d [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [XLEN-1:0]    tgt_d [ENTRIES];
  logic [ENTRIES-1:0] jmp_q, jmp_d;
  logic [31:0]        cnt_q, cnt_d;

  // Instruction addresses are word aligned; the low PC bits never index or tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pc_if[1:0], pc_ex[1:0]};

  // IF lookup
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx = pc_if[IDX_W+1:2];
  assign if_tag = pc_if[XLEN-1:IDX_W+2];
  assign if_hit = valid_q[if_idx] & (tag_q[if_idx] == if_tag);

  assign pred_taken_if  = if_hit & (jmp_q[if_idx] | ctr_q[if_idx][1]);
  assign pred_target_if = pred_taken_if ? tgt_q[if_idx] : pc_if + XLEN'(4);

  // EX resolution
  logic             cond;
  logic             is_cf;
  logic             actual_taken;
  logic             mispredict;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;

  branch_cond_decode u_cond_decode (
    .fun3_i  (fun3),
    .beq_i   (beq),
    .blt_i   (blt),
    .cond_o  (cond),
    .br_un_o (BrUn)
  );

  assign is_cf        = Branch | Jump;
  assign actual_taken = Jump | (Branch & cond);

  // A non-control-flow instruction predicted taken is a BTB alias and must redirect.
  assign mispredict = ex_valid &
                      ((is_cf & ((actual_taken != pred_taken_ex) |
                                 (actual_taken & (target_ex != pred_target_ex)))) |
                       (~is_cf & pred_taken_ex));

  assign PcSrc       = mispredict;
  assign flush       = mispredict;
  assign redirect_pc = actual_taken ? target_ex : pc_ex + XLEN'(4);

  assign ex_idx = pc_ex[IDX_W+1:2];
  assign ex_tag = pc_ex[XLEN-1:IDX_W+2];
  assign ex_hit = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);

  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    jmp_d   = jmp_q;
    if (ex_valid && is_cf) begin
      if (ex_hit) begin
        if (Jump) begin
          tgt_d[ex_idx] = target_ex;
          jmp_d[ex_idx] = 1'b1;
        end else begin
          ctr_d[ex_idx] = ctr_next(ctr_q[ex_idx], actual_taken);
          if (actual_taken) begin
            tgt_d[ex_idx] = target_ex;
          end
        end
      end else if (actual_taken) begin
        valid_d[ex_idx] = 1'b1;
        tag_d[ex_idx]   = ex_tag;
        tgt_d[ex_idx]   = target_ex;
        jmp_d[ex_idx]   = Jump;
        ctr_d[ex_idx]   = CtrWeakT;
      end
    end else if (ex_valid && pred_taken_ex && ex_hit) begin
      valid_d[ex_idx] = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (mispredict && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  assign mispredict_count = cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CtrWeakNt;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ctr_q   <= ctr_d;
    end
  end

  // Payload fields are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
    jmp_q <= jmp_d;
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural table model.
module tb_branch_predict_unit;

  localparam int unsigned ENTRIES = 64;
  localparam int unsigned IDX_W   = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_if;
  logic        pred_taken_if;
  logic [31:0] pred_target_if;
  logic        ex_valid, Branch, Jump, beq, blt;
  logic [2:0]  fun3;
  logic        BrUn;
  logic [31:0] pc_ex, target_ex;
  logic        pred_taken_ex;
  logic [31:0] pred_target_ex;
  logic        PcSrc, flush;
  logic [31:0] redirect_pc;
  logic [31:0] mispredict_count;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .XLEN    (32),
    .ENTRIES (64)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pc_if            (pc_if),
    .pred_taken_if    (pred_taken_if),
    .pred_target_if   (pred_target_if),
    .ex_valid         (ex_valid),
    .Branch           (Branch),
    .Jump             (Jump),
    .beq              (beq),
    .blt              (blt),
    .fun3             (fun3),
    .BrUn             (BrUn),
    .pc_ex            (pc_ex),
    .target_ex        (target_ex),
    .pred_taken_ex    (pred_taken_ex),
    .pred_target_ex   (pred_target_ex),
    .PcSrc            (PcSrc),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .mispredict_count (mispredict_count)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the tables
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  bit          m_jmp   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_count;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_jmp[idx_of(pc)] || (m_ctr[idx_of(pc)] >= 2));
  endfunction

  function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
    return m_pred_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit exp_taken();
    bit c;
    case (fun3)
      3'd0:       c = beq;
      3'd1:       c = !beq;
      3'd4, 3'd6: c = blt;
      3'd5, 3'd7: c = !blt;
      default:    c = 1'b0;
    endcase
    return Jump || (Branch && c);
  endfunction

  function automatic bit exp_mp();
    if (!ex_valid) return 1'b0;
    if (Branch || Jump)
      return (exp_taken() != pred_taken_ex) || (exp_taken() && (target_ex != pred_target_ex));
    return pred_taken_ex;
  endfunction

  function automatic logic [31:0] exp_redirect();
    return exp_taken() ? target_ex : pc_ex + 32'd4;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] <= 1'b0;
        m_ctr[i]   <= 1;
      end
      m_count <= '0;
    end else begin
      if (exp_mp() && (m_count != 32'hFFFF_FFFF)) m_count <= m_count + 32'd1;
      if (ex_valid && (Branch || Jump)) begin
        if (m_hit(pc_ex)) begin
          if (Jump) begin
            m_tgt[idx_of(pc_ex)] <= target_ex;
            m_jmp[idx_of(pc_ex)] <= 1'b1;
          end else begin
            if (exp_taken()) begin
              m_ctr[idx_of(pc_ex)] <= (m_ctr[idx_of(pc_ex)] == 3) ? 3 : m_ctr[idx_of(pc_ex)] + 1;
              m_tgt[idx_of(pc_ex)] <= target_ex;
            end else begin
              m_ctr[idx_of(pc_ex)] <= (m_ctr[idx_of(pc_ex)] == 0) ? 0 : m_ctr[idx_of(pc_ex)] - 1;
            end
          end
        end else if (exp_taken()) begin
          m_valid[idx_of(pc_ex)] <= 1'b1;
          m_tag[idx_of(pc_ex)]   <= tag_of(pc_ex);
          m_tgt[idx_of(pc_ex)]   <= target_ex;
          m_jmp[idx_of(pc_ex)]   <= Jump;
          m_ctr[idx_of(pc_ex)]   <= 2;
        end
      end else if (ex_valid && pred_taken_ex && m_hit(pc_ex)) begin
        m_valid[idx_of(pc_ex)] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pred_taken_if", {31'd0, pred_taken_if}, {31'd0, m_pred_taken(pc_if)});
      chk("pred_target_if", pred_target_if, m_pred_tgt(pc_if));
      chk("PcSrc", {31'd0, PcSrc}, {31'd0, exp_mp()});
      chk("flush", {31'd0, flush}, {31'd0, exp_mp()});
      chk("redirect_pc", redirect_pc, exp_redirect());
      chk("BrUn", {31'd0, BrUn}, {31'd0, fun3[1]});
      chk("mispredict_count", mispredict_count, m_count);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ex_valid = 0; Branch = 0; Jump = 0; beq = 0; blt = 0; fun3 = 3'd0;
    pc_ex = 32'h0; target_ex = 32'h0; pred_taken_ex = 0; pred_target_ex = 32'h4;
  endtask

  task automatic ex_set(input bit v, input bit br, input bit jp, input logic [2:0] f3,
                        input bit eq, input bit lt, input logic [31:0] pc,
                        input logic [31:0] tgt, input bit pt, input logic [31:0] ptgt);
    ex_valid = v; Branch = br; Jump = jp; fun3 = f3; beq = eq; blt = lt;
    pc_ex = pc; target_ex = tgt; pred_taken_ex = pt; pred_target_ex = ptgt;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
    return ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 2);
  endfunction

  function automatic logic [31:0] rand_tgt();
    return 32'h1000 * $urandom_range(1, 2) + 32'd4 * $urandom_range(0, 1);
  endfunction

  initial begin
    reset_n = 1'b1;
    pc_if   = 32'h100;
    ex_idle();
    #1 reset_n = 1'b0;
    cmp_en = 1'b1;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_pred_taken", {31'd0, pred_taken_if}, 32'd0);
    chk("rst_pred_target", pred_target_if, 32'h104);
    chk("rst_count", mispredict_count, 32'd0);

    // BEQ taken, cold miss: allocates weakly taken
    next_cycle();
    ex_set(1, 1, 0, 3'd0, 1, 0, 32'h100, 32'h80, 0, 32'h104);
    @(negedge clk);
    chk("beq_alloc_pcsrc", {31'd0, PcSrc}, 32'd1);
    chk("beq_alloc_redirect", redirect_pc, 32'h80);
    next_cycle();
    ex_idle();
    @(negedge clk);
    chk("beq_trained_taken", {31'd0, pred_taken_if}, 32'd1);
    chk("beq_trained_target", pred_target_if, 32'h80);
    chk("beq_count1", mispredict_count, 32'd1);

    // Same BEQ not taken three times, predictions fed from the model
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      ex_set(1, 1, 0, 3'd0, 0, 0, 32'h100, 32'h80, m_pred_taken(32'h100), m_pred_tgt(32'h100));
      @(negedge clk);
      chk("beq_nt_pcsrc", {31'd0, PcSrc}, (k == 0) ? 32'd1 : 32'd0);
    end
    next_cycle();
    ex_idle();
    @(negedge clk);
    chk("beq_nt_count", mispredict_count, 32'd2);
    chk("beq_nt_pred", {31'd0, pred_taken_if}, 32'd0);

    // JALR trained to 0x400, then resolves to 0x500
    next_cycle();
    ex_set(1, 0, 1, 3'd0, 0, 0, 32'h200, 32'h400, 0, 32'h204);
    pc_if = 32'h200;
    @(negedge clk);
    chk("jalr_alloc_redirect", redirect_pc, 32'h400);
    next_cycle();
    ex_idle();
    @(negedge clk);
    chk("jalr_pred_target", pred_target_if, 32'h400);
    next_cycle();
    ex_set(1, 0, 1, 3'd0, 0, 0, 32'h200, 32'h500, 1, 32'h400);
    @(negedge clk);
    chk("jalr_retarget_pcsrc", {31'd0, PcSrc}, 32'd1);
    chk("jalr_retarget_redirect", redirect_pc, 32'h500);
    next_cycle();
    ex_idle();
    @(negedge clk);
    chk("jalr_new_target", pred_target_if, 32'h500);
    chk("jalr_count", mispredict_count, 32'd4);

    // Alias: non-branch predicted taken invalidates the entry
    next_cycle();
    ex_set(1, 0, 0, 3'd0, 0, 0, 32'h200, 32'h0, 1, 32'h500);
    @(negedge clk);
    chk("alias_pcsrc", {31'd0, PcSrc}, 32'd1);
    chk("alias_redirect", redirect_pc, 32'h204);
    next_cycle();
    ex_idle();
    @(negedge clk);
    chk("alias_invalidated", {31'd0, pred_taken_if}, 32'd0);
    chk("alias_count", mispredict_count, 32'd5);

    // fun3=010 never taken, never allocates
    next_cycle();
    ex_set(1, 1, 0, 3'b010, 1, 1, 32'h300, 32'h900, 0, 32'h304);
    pc_if = 32'h300;
    @(negedge clk);
    chk("f3_010_pcsrc", {31'd0, PcSrc}, 32'd0);
    chk("f3_010_redirect", redirect_pc, 32'h304);
    next_cycle();
    // ex_valid low: nothing trains even for a taken branch
    ex_set(0, 1, 0, 3'd0, 1, 0, 32'h300, 32'h900, 0, 32'h304);
    @(negedge clk);
    chk("f3_010_no_alloc", {31'd0, pred_taken_if}, 32'd0);
    chk("bubble_pcsrc", {31'd0, PcSrc}, 32'd0);
    next_cycle();
    ex_idle();
    @(negedge clk);
    chk("bubble_no_alloc", {31'd0, pred_taken_if}, 32'd0);
    chk("bubble_count", mispredict_count, 32'd5);

    // Reset asserted across an allocating update
    next_cycle();
    ex_set(1, 1, 0, 3'd0, 1, 0, 32'h500, 32'h40, 0, 32'h504);
    pc_if = 32'h500;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("rst_pcsrc_comb", {31'd0, PcSrc}, 32'd1);
    next_cycle();
    reset_n = 1'b1;
    ex_idle();
    @(negedge clk);
    chk("rst_no_write", {31'd0, pred_taken_if}, 32'd0);
    chk("rst_count_clear", mispredict_count, 32'd0);

    // PC wrap
    next_cycle();
    pc_if = 32'hFFFF_FFFC;
    ex_set(1, 0, 0, 3'd0, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk("wrap_pred_target", pred_target_if, 32'h0);
    chk("wrap_redirect", redirect_pc, 32'h0);

    // Randomized traffic, checked each cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      reset_n = 1'b1;
      pc_if   = rand_pc();
      ex_valid = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 2))
        0:       begin Branch = 1; Jump = 0; end
        1:       begin Branch = 0; Jump = 1; end
        default: begin Branch = 0; Jump = 0; end
      endcase
      fun3      = 3'($urandom_range(0, 7));
      beq       = 1'($urandom_range(0, 1));
      blt       = 1'($urandom_range(0, 1));
      pc_ex     = rand_pc();
      target_ex = rand_tgt();
      if ($urandom_range(0, 9) < 7) begin
        pred_taken_ex  = m_pred_taken(pc_ex);
        pred_target_ex = m_pred_tgt(pc_ex);
      end else begin
        pred_taken_ex  = 1'($urandom_range(0, 1));
        pred_target_ex = pred_taken_ex ? rand_tgt() : pc_ex + 32'd4;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 reset_n = 1'b0;
      end
    end

    next_cycle();
    reset_n = 1'b1;
    ex_idle();
    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
